psram_qpi_writer: RTL

PSRAM_QPI_WRITER -- requirements
Module: psram_qpi_writer

---
 rtl/psram_qpi_writer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/psram_qpi_writer.sv
// ---------------------------------------------------------------------------
// psram_qpi_writer
//
// Drains a show-ahead write FIFO into a QPI PSRAM using fixed-length
// Quad Write (0x38) bursts. Each burst is:
//   CMD  : 2 nibbles (3, 8)
//   ADDR : 6 nibbles of {1'b0, addr[22:0]}, MSB nibble first, no wait cycles
//   DATA : 4*BURST_HW nibbles, each halfword sent [15:12] down to [3:0]
//   CEH  : CE_HIGH_CYCLES cycles of chip-enable high recovery
// The pin bus is shared; the block requests it via bus_req/bus_gnt and keeps
// bus_req high from acceptance until recovery ends.
//
// Optional feature (macro PSRAM_WR_STOP_AT_END_EN):
//   defined   - after the burst at the top of memory completes, mem_full is
//               set and no further bursts start until addr_load clears it.
//   undefined - address wraps to 0 and mem_full is tied low.
//
// Ports:
//   clk, reset          system clock (rising edge), async active-high reset
//   psram_ready         PSRAM QPI init sequence finished
//   enable              level, permits new bursts
//   addr_load, addr_in  one-cycle pulse loading the byte start address
//   bus_req, bus_gnt    PSRAM pin arbitration handshake
//   wrfifo_q            show-ahead FIFO head word
//   wrfifo_rdusedw      FIFO fill level
//   wrfifo_rdreq        one-cycle pop strobe
//   psram_cs_n          chip enable (active low), also clock-gate enable
//   psram_sio_out       QPI nibble, SIO[3] = MSB
//   psram_sio_dir       1 = FPGA drives SIO pins
//   psram_cmd_dir       1 = FPGA drives CMD pins
//   busy                burst in flight (acceptance through recovery)
//   mem_full            end of memory reached (macro builds only)
// ---------------------------------------------------------------------------
module psram_qpi_writer #(
    parameter int BURST_HW       = 16,
    parameter int CE_HIGH_CYCLES = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psram_ready,
    input  logic        enable,
    input  logic        addr_load,
    input  logic [22:0] addr_in,
    output logic        bus_req,
    input  logic        bus_gnt,
    input  logic [15:0] wrfifo_q,
    input  logic [9:0]  wrfifo_rdusedw,
    output logic        wrfifo_rdreq,
    output logic        psram_cs_n,
    output logic [3:0]  psram_sio_out,
    output logic        psram_sio_dir,
    output logic        psram_cmd_dir,
    output logic        busy,
    output logic        mem_full
);

    localparam int DATA_CYC = 4 * BURST_HW;
    // Bursts are aligned to their own size (never below 32 bytes) so they
    // can never straddle a 1 KB page.
    localparam int ALIGN_RAW = $clog2(2 * BURST_HW);
    localparam int ALIGN     = (ALIGN_RAW < 5) ? 5 : ALIGN_RAW;
    localparam int CNT_W     = $clog2(DATA_CYC + CE_HIGH_CYCLES + 8);

    localparam logic [22:0]      ADDR_MASK = ~23'((1 << ALIGN) - 1);
    localparam logic [22:0]      ADDR_STEP = 23'(2 * BURST_HW);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(5);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_CYC - 1);
    localparam logic [CNT_W-1:0] CEH_LAST  = CNT_W'(CE_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        CEH  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [22:0]      addr_q, addr_d;    // next burst start address
    logic [22:0]      baddr_q, baddr_d;  // address of the burst in flight
    logic [15:0]      sh_q, sh_d;        // data nibble shifter
    logic             gap_q, gap_d;      // forces one bus_req-low IDLE cycle
    logic             full_q, full_d;

    logic             req_ok;
    logic             bus_req_c;
    logic [23:0]      addr24;

    assign addr24 = {1'b0, baddr_q};

    assign req_ok = psram_ready & enable & ~full_q & ~gap_q &
                    (wrfifo_rdusedw >= 10'(BURST_HW));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            baddr_q <= '0;
            sh_q    <= '0;
            gap_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            baddr_q <= baddr_d;
            sh_q    <= sh_d;
            gap_q   <= gap_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        addr_d        = addr_q;
        baddr_d       = baddr_q;
        sh_d          = sh_q;
        gap_d         = 1'b0;
        full_d        = full_q;
        bus_req_c     = 1'b0;
        wrfifo_rdreq  = 1'b0;
        psram_cs_n    = 1'b1;
        psram_sio_out = 4'hF;
        psram_sio_dir = 1'b0;
        psram_cmd_dir = 1'b0;
        busy          = 1'b0;

        case (state_q)
            IDLE: begin
                bus_req_c = req_ok;
                cnt_d     = '0;
                // A load in the acceptance cycle takes priority; the burst
                // then starts a cycle later with the new address.
                if (addr_load) begin
                    addr_d = addr_in & ADDR_MASK;
                    full_d = 1'b0;
                end else if (req_ok && bus_gnt) begin
                    state_d = CMD;
                end
            end

            CMD: begin
                bus_req_c     = 1'b1;
                busy          = 1'b1;
                psram_cs_n    = 1'b0;
                psram_sio_dir = 1'b1;
                psram_cmd_dir = 1'b1;
                psram_sio_out = cnt_q[0] ? 4'h8 : 4'h3;
                if (cnt_q == CMD_LAST) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                    baddr_d = addr_q;
                    addr_d  = addr_q + ADDR_STEP;  // wraps modulo 2^23
                end
            end

            ADDR: begin
                bus_req_c     = 1'b1;
                busy          = 1'b1;
                psram_cs_n    = 1'b0;
                psram_sio_dir = 1'b1;
                psram_cmd_dir = 1'b1;
                psram_sio_out = 4'(addr24 >> {3'd5 - cnt_q[2:0], 2'b00});
                if (cnt_q == ADDR_LAST) begin
                    // Preload the first halfword so data follows with no gap.
                    wrfifo_rdreq = 1'b1;
                    sh_d         = wrfifo_q;
                    state_d      = DATA;
                    cnt_d        = '0;
                end
            end

            DATA: begin
                bus_req_c     = 1'b1;
                busy          = 1'b1;
                psram_cs_n    = 1'b0;
                psram_sio_dir = 1'b1;
                psram_cmd_dir = 1'b1;
                psram_sio_out = sh_q[15:12];
                sh_d          = {sh_q[11:0], 4'h0};
                if (cnt_q == DATA_LAST) begin
                    state_d = CEH;
                    cnt_d   = '0;
`ifdef PSRAM_WR_STOP_AT_END_EN
                    // The pointer has already advanced; zero means this
                    // burst was the last one before the top of memory.
                    if (addr_q == '0) full_d = 1'b1;
`endif
                end else if (cnt_q[1:0] == 2'b11) begin
                    wrfifo_rdreq = 1'b1;
                    sh_d         = wrfifo_q;
                end
            end

            CEH: begin
                bus_req_c = 1'b1;
                busy      = 1'b1;
                if (cnt_q == CEH_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    gap_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Gate with reset so the request is low while reset is held even if the
    // request conditions are already met.
    assign bus_req  = bus_req_c & ~reset;
    assign mem_full = full_q;

endmodule
